histogram_dump_reader: RTL and testbench

Reads the duration histogram out of the shared result BRAM and streams it to the host side. The BRAM writer increments 32-bit bins at byte address `duration*4` and, after the final run, writes the completion marker `32'hffffffff` to address 0. This block sits on the other BRAM port and is the consumer of that protocol. It polls address 0 for the marker, streams bins 1..NUM_BINS-1 over a valid/ready interface, optionally zeroes each bin after it is read, then clears the marker so the next experiment can start.

---
 rtl/histogram_dump_reader.sv | 161 ++++++++++++++++
 tb/tb_histogram_dump_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_dump_reader.sv
// Drains the duration histogram from the shared result BRAM once the writer has
// left its completion marker at word 0, optionally zeroing bins as they go out.
module histogram_dump_reader #(
   parameter int          NUM_BINS      = 256,
   parameter logic [31:0] POLL_INTERVAL = 32'd1000,
   parameter bit          CLEAR_ON_READ = 1'b1,
   parameter logic [31:0] DONE_MARKER   = 32'hffffffff
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [3:0]  we,
   output logic        en,
   output logic [31:0] addr,
   output logic [31:0] di,
   input  logic [31:0] dout,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        dump_done,
   output logic [31:0] dump_count,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      WAIT       = 3'd0,
      POLL_ADDR  = 3'd1,
      POLL_CHECK = 3'd2,
      RD_ADDR    = 3'd3,
      RD_CAPTURE = 3'd4,
      SEND       = 3'd5,
      CLEAR      = 3'd6,
      FINISH     = 3'd7
   } state_t;

   localparam logic [31:0] LAST_BIN   = 32'(NUM_BINS - 1);
   localparam logic [31:0] POLL_LIMIT = POLL_INTERVAL - 32'd1;

   state_t      state, state_n;
   logic [31:0] poll_cnt, poll_cnt_n;
   logic [31:0] bin, bin_n;
   logic [31:0] m_data_n;
   logic        m_valid_n, m_last_n;
   logic        dump_done_n;
   logic [31:0] dump_count_n;
   logic [31:0] bin_addr;
   logic        last_bin;

   assign en        = 1'b1;
   assign state_dbg = state;
   assign bin_addr  = {bin[29:0], 2'b00};
   assign last_bin  = (bin == LAST_BIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= WAIT;
         poll_cnt   <= 32'd0;
         bin        <= 32'd0;
         m_data     <= 32'd0;
         m_valid    <= 1'b0;
         m_last     <= 1'b0;
         dump_done  <= 1'b0;
         dump_count <= 32'd0;
      end else begin
         state      <= state_n;
         poll_cnt   <= poll_cnt_n;
         bin        <= bin_n;
         m_data     <= m_data_n;
         m_valid    <= m_valid_n;
         m_last     <= m_last_n;
         dump_done  <= dump_done_n;
         dump_count <= dump_count_n;
      end
   end

   // Stream handshake: a word transfers on a clock edge where m_valid && m_ready;
   // once raised, m_valid/m_data/m_last hold until that edge (only reset drops them).
   always_comb begin
      state_n      = state;
      poll_cnt_n   = poll_cnt;
      bin_n        = bin;
      m_data_n     = m_data;
      m_valid_n    = m_valid;
      m_last_n     = m_last;
      dump_done_n  = 1'b0;
      dump_count_n = dump_count;
      we           = 4'b0000;
      di           = 32'd0;
      addr         = bin_addr;

      case (state)
         WAIT: begin
            addr       = 32'd0;
            poll_cnt_n = poll_cnt + 32'd1;
            if (enable && (poll_cnt >= POLL_LIMIT)) begin
               poll_cnt_n = 32'd0;
               state_n    = POLL_ADDR;
            end
         end
         POLL_ADDR: begin
            addr    = 32'd0;
            state_n = POLL_CHECK;
         end
         POLL_CHECK: begin
            if (dout == DONE_MARKER) begin
               bin_n   = 32'd1;
               state_n = RD_ADDR;
            end else begin
               state_n = WAIT;
            end
         end
         RD_ADDR: begin
            state_n = RD_CAPTURE;
         end
         RD_CAPTURE: begin
            m_data_n  = dout;
            m_valid_n = 1'b1;
            m_last_n  = last_bin;
            state_n   = SEND;
         end
         SEND: begin
            if (m_valid && m_ready) begin
               m_valid_n = 1'b0;
               m_last_n  = 1'b0;
               if (CLEAR_ON_READ) begin
                  state_n = CLEAR;
               end else if (last_bin) begin
                  state_n = FINISH;
               end else begin
                  bin_n   = bin + 32'd1;
                  state_n = RD_ADDR;
               end
            end
         end
         CLEAR: begin
            we = 4'b1111;
            if (last_bin) begin
               state_n = FINISH;
            end else begin
               bin_n   = bin + 32'd1;
               state_n = RD_ADDR;
            end
         end
         FINISH: begin
            we           = 4'b1111;
            addr         = 32'd0;
            dump_done_n  = 1'b1;
            dump_count_n = dump_count + 32'd1;
            state_n      = WAIT;
         end
         default: state_n = WAIT;
      endcase

      // A reset arriving mid-dump must not let the pending clear or marker write land.
      if (reset) begin
         we = 4'b0000;
      end
   end

endmodule

// File: tb/tb_histogram_dump_reader.sv
// Directed bench for histogram_dump_reader: two instances (clear-on-read on and off),
// each attached to a small registered-read BRAM model.
module tb_histogram_dump_reader;

   localparam int NB = 8;
   localparam int PI = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic m_ready = 1'b0;
   logic [1:0] init_a = 2'd0;
   logic [1:0] init_b = 2'd0;

   logic [3:0]  a_we, b_we;
   logic        a_en, b_en;
   logic [31:0] a_addr, b_addr, a_di, b_di;
   logic [31:0] a_dout = 32'd0;
   logic [31:0] b_dout = 32'd0;
   logic [31:0] a_data, b_data, a_count, b_count;
   logic        a_valid, b_valid, a_last, b_last, a_done, b_done;
   logic [2:0]  a_state, b_state;

   logic [31:0] mem_a [NB];
   logic [31:0] mem_b [NB];
   logic [31:0] exp_q [$];

   int checks = 0;
   int errors = 0;
   int done_cnt_a = 0;

   always #5 clk = ~clk;

   histogram_dump_reader #(.NUM_BINS(NB), .POLL_INTERVAL(32'(PI)), .CLEAR_ON_READ(1'b1),
                           .DONE_MARKER(32'hffffffff)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .we(a_we), .en(a_en), .addr(a_addr),
      .di(a_di), .dout(a_dout), .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready),
      .m_last(a_last), .dump_done(a_done), .dump_count(a_count), .state_dbg(a_state));

   histogram_dump_reader #(.NUM_BINS(NB), .POLL_INTERVAL(32'(PI)), .CLEAR_ON_READ(1'b0),
                           .DONE_MARKER(32'hffffffff)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .we(b_we), .en(b_en), .addr(b_addr),
      .di(b_di), .dout(b_dout), .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready),
      .m_last(b_last), .dump_done(b_done), .dump_count(b_count), .state_dbg(b_state));

   // BRAM models: init 1 loads marker + k*3 pattern, init 2 the same pattern without marker.
   always @(posedge clk) begin
      if (init_a != 2'd0) begin
         for (int k = 0; k < NB; k++)
            mem_a[k] <= (k == 0) ? ((init_a == 2'd1) ? 32'hffffffff : 32'd0) : 32'(k * 3);
      end else if (a_en) begin
         for (int i = 0; i < 4; i++)
            if (a_we[i]) mem_a[a_addr[4:2]][8*i +: 8] <= a_di[8*i +: 8];
      end
      a_dout <= mem_a[a_addr[4:2]];
   end

   always @(posedge clk) begin
      if (init_b != 2'd0) begin
         for (int k = 0; k < NB; k++)
            mem_b[k] <= (k == 0) ? ((init_b == 2'd1) ? 32'hffffffff : 32'd0) : 32'(k * 3);
      end else if (b_en) begin
         for (int i = 0; i < 4; i++)
            if (b_we[i]) mem_b[b_addr[4:2]][8*i +: 8] <= b_di[8*i +: 8];
      end
      b_dout <= mem_b[b_addr[4:2]];
   end

   always @(posedge clk) if (a_done) done_cnt_a <= done_cnt_a + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_mem(input bit sel, input logic [1:0] cmd);
      if (sel) init_b = cmd; else init_a = cmd;
      @(posedge clk); #1;
      init_a = 2'd0;
      init_b = 2'd0;
   endtask

   task automatic push_pattern(input int first_zero_bins, input int skip_clear);
      exp_q.delete();
      for (int k = 1; k < NB; k++)
         exp_q.push_back((k <= first_zero_bins && k != skip_clear) ? 32'd0 : 32'(k * 3));
   endtask

   task automatic run_frame(input bit sel, input int ready_pct, input int max_cyc, output int got);
      logic v, l;
      logic [31:0] d, prev_d, e;
      bit stalled, done;
      int cyc;
      got = 0; stalled = 0; done = 0; cyc = 0; prev_d = 32'd0;
      while (!done && cyc < max_cyc) begin
         @(posedge clk); #1;
         cyc++;
         v = sel ? b_valid : a_valid;
         d = sel ? b_data  : a_data;
         l = sel ? b_last  : a_last;
         if (stalled) begin
            chk("stall_valid", 32'(v), 32'd1);
            chk("stall_data", d, prev_d);
         end
         m_ready = ($urandom_range(0, 99) < ready_pct);
         if (v && m_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdeadbeef;
            chk("word_data", d, e);
            chk("word_last", 32'(l), 32'(exp_q.size() == 0));
            got++;
            if (l) done = 1;
            stalled = 0;
         end else begin
            stalled = v;
            prev_d  = d;
         end
      end
      chk("frame_complete", 32'(done), 32'd1);
      m_ready = 1'b1;
   endtask

   initial begin
      int got, last_poll, gaps, we_bad, v_bad, n, cyc, poll_bad;
      bit seen;

      // Reset and preload both memories without marker
      init_a = 2'd2;
      init_b = 2'd2;
      repeat (3) @(posedge clk);
      #1;
      init_a = 2'd0;
      init_b = 2'd0;
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_last", 32'(a_last), 32'd0);
      chk("rst_data", a_data, 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_count", a_count, 32'd0);
      chk("rst_we", 32'(a_we), 32'd0);
      chk("rst_addr", a_addr, 32'd0);
      chk("rst_en", 32'(a_en), 32'd1);
      chk("rst_state_b", 32'(b_state), 32'd0);
      reset = 1'b0;

      // No marker: periodic polls of address 0, never a stream or a write
      enable = 1'b1;
      m_ready = 1'b1;
      last_poll = -1; gaps = 0; we_bad = 0; v_bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (a_we != 4'd0) we_bad++;
         if (a_valid) v_bad++;
         if (a_state == 3'd1) begin
            chk("poll_addr", a_addr, 32'd0);
            if (last_poll >= 0 && gaps < 4) begin
               chk("poll_period", 32'(c - last_poll), 32'(PI + 2));
               gaps++;
            end
            last_poll = c;
         end
      end
      chk("idle_writes", 32'(we_bad), 32'd0);
      chk("idle_valid", 32'(v_bad), 32'd0);
      chk("idle_polls_seen", 32'(gaps), 32'd4);

      // Basic dump with clear-on-read
      load_mem(1'b0, 2'd1);
      push_pattern(0, 0);
      run_frame(1'b0, 100, 300, got);
      chk("basic_words", 32'(got), 32'd7);
      repeat (6) @(posedge clk);
      #1;
      for (int k = 0; k < NB; k++) chk($sformatf("basic_zero_%0d", k), mem_a[k], 32'd0);
      chk("basic_done_pulses", 32'(done_cnt_a), 32'd1);
      chk("basic_count", a_count, 32'd1);

      // Backpressure: same data under random ready
      load_mem(1'b0, 2'd1);
      push_pattern(0, 0);
      run_frame(1'b0, 30, 3000, got);
      chk("bp_words", 32'(got), 32'd7);
      repeat (6) @(posedge clk);
      #1;
      chk("bp_done_pulses", 32'(done_cnt_a), 32'd2);
      chk("bp_count", a_count, 32'd2);

      // No clear-on-read: bins survive, marker cleared, no repeat dump
      load_mem(1'b1, 2'd1);
      push_pattern(0, 0);
      run_frame(1'b1, 100, 300, got);
      chk("nc_words", 32'(got), 32'd7);
      repeat (6) @(posedge clk);
      #1;
      chk("nc_marker", mem_b[0], 32'd0);
      for (int k = 1; k < NB; k++) chk($sformatf("nc_bin_%0d", k), mem_b[k], 32'(k * 3));
      chk("nc_count", b_count, 32'd1);
      v_bad = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (b_valid) v_bad++;
      end
      chk("nc_no_redump", 32'(v_bad), 32'd0);

      // Reset one cycle after the third handshake
      load_mem(1'b0, 2'd1);
      n = 0; cyc = 0;
      while (n < 3 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (a_valid) begin
            chk("pre_reset_data", a_data, 32'(3 * (n + 1)));
            n++;
         end
      end
      chk("pre_reset_handshakes", 32'(n), 32'd3);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_valid", 32'(a_valid), 32'd0);
      chk("mid_rst_last", 32'(a_last), 32'd0);
      chk("mid_rst_data", a_data, 32'd0);
      chk("mid_rst_count", a_count, 32'd0);
      chk("mid_rst_state", 32'(a_state), 32'd0);
      chk("mid_rst_marker", mem_a[0], 32'hffffffff);
      chk("mid_rst_bin2", mem_a[2], 32'd0);
      chk("mid_rst_bin3", mem_a[3], 32'd9);
      push_pattern(3, 3);
      run_frame(1'b0, 100, 300, got);
      chk("restart_words", 32'(got), 32'd7);
      enable = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("restart_count", a_count, 32'd1);

      // Marker set but polling disarmed, then armed
      load_mem(1'b0, 2'd1);
      poll_bad = 0; v_bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (a_state == 3'd1) poll_bad++;
         if (a_valid) v_bad++;
      end
      chk("disarmed_polls", 32'(poll_bad), 32'd0);
      chk("disarmed_valid", 32'(v_bad), 32'd0);
      chk("disarmed_marker", mem_a[0], 32'hffffffff);
      m_ready = 1'b0;
      enable = 1'b1;
      seen = 0; cyc = 0;
      while (!seen && cyc < PI + 5) begin
         @(posedge clk); #1;
         cyc++;
         if (a_valid) seen = 1;
      end
      chk("armed_start", 32'(seen), 32'd1);
      push_pattern(0, 0);
      run_frame(1'b0, 100, 300, got);
      chk("armed_words", 32'(got), 32'd7);
      repeat (6) @(posedge clk);
      #1;
      chk("armed_count", a_count, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
